// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - state encoding and strobe constants shared by the APB master files
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [3:0] STB_NONE = 4'b0000;
  localparam logic [3:0] STB_ALL  = 4'b1111;

endpackage

// File: rtl/apb_timeout.sv
// rtl/apb_timeout.sv - saturating ACCESS-cycle counter that flags an unanswered transfer
module apb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of ACCESS cycles already completed, so the
  // TIMEOUT-th cycle is the one where count has reached TIMEOUT-1.
  assign expired = (TIMEOUT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - bridges a valid/ready request port onto a single-outstanding APB bus
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [3:0]            req_stb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  ready,
  input  logic                  perr
);

  state_t state, state_next;
  logic   accept;
  logic   expired;

  assign accept = req_valid && req_ready;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = SETUP;
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (ready || expired) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  apb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (pclk),
    .rst    (prst),
    .clear  (state == SETUP),
    .enable (state == ACCESS),
    .expired(expired)
  );

  // Bus fields only load on acceptance, so they stay stable through SETUP/ACCESS
  // and keep their last values while idle.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      paddr     <= '0;
      pdata     <= '0;
      pwrite    <= 1'b0;
      pstb      <= STB_NONE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        paddr  <= req_addr;
        pdata  <= req_wdata;
        pwrite <= req_write;
        pstb   <= req_write ? req_stb : STB_NONE;
      end
      if (state == ACCESS) begin
        if (ready) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_err   <= perr;
        end else if (expired) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a randomized APB responder
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          prst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_write = 1'b0;
  logic [3:0]    req_stb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pdata;
  logic [DW-1:0] prdata = '0;
  logic          psel, penable, pwrite;
  logic [3:0]    pstb;
  logic          ready = 1'b0;
  logic          perr = 1'b0;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_stb(req_stb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pstb(pstb), .ready(ready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
    logic [3:0]    stb;
    logic [DW-1:0] rdata;
    logic          err;
    int            latency;
    int            acc_cyc;
  } exp_t;

  typedef struct {
    int            waits;
    logic [DW-1:0] prdata;
    logic          perr;
  } rsp_cfg_t;

  exp_t     sb[$];
  rsp_cfg_t rq[$];
  int       gaps[$];
  int       rsp_cycles[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       setup_seen = 0;
  int       access_seen = 0;

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: W ACCESS cycles of wait before ready; a transfer needing more
  // than TO ACCESS cycles is cut off by the timeout after exactly TO of them.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                      input logic [3:0] s, input int waits, input logic [DW-1:0] rd,
                      input logic pe);
    exp_t     e;
    rsp_cfg_t r;
    int       guard = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_write = w;
    req_stb   = s;
    forever begin
      @(negedge pclk);
      if (req_ready) break;
      guard++;
      if (guard > 40) begin
        check("accept_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
    end
    e.addr  = a;
    e.wdata = d;
    e.write = w;
    e.stb   = w ? s : 4'b0000;
    if (waits + 1 <= TO) begin
      e.err     = pe;
      e.rdata   = w ? '0 : rd;
      e.latency = 3 + waits;
    end else begin
      e.err     = 1'b1;
      e.rdata   = '0;
      e.latency = 2 + TO;
    end
    e.acc_cyc = cyc;
    r.waits   = waits;
    r.prdata  = rd;
    r.perr    = pe;
    sb.push_back(e);
    rq.push_back(r);
    @(posedge pclk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    req_valid = 1'b0;
    while (sb.size() > 0 && g < 60) begin
      @(posedge pclk);
      g++;
    end
    if (sb.size() > 0) check("drain_timeout", 64'(sb.size()), 0);
    @(posedge pclk);
    #1;
  endtask

  // Responder: answers after the configured wait count and drives junk on
  // ready/perr/prdata whenever the master is not in ACCESS.
  initial begin
    rsp_cfg_t cur;
    int       n = 0;
    cur = '{waits: 0, prdata: '0, perr: 1'b0};
    forever begin
      @(negedge pclk);
      if (prst) begin
        ready = 1'b0;
        perr  = 1'b0;
        n     = 0;
      end else if (psel && penable) begin
        n++;
        if (n > cur.waits) begin
          ready  = 1'b1;
          perr   = cur.perr;
          prdata = cur.prdata;
        end else begin
          ready  = 1'b0;
          perr   = 1'($urandom_range(0, 1));
          prdata = $urandom;
        end
      end else begin
        if (psel) begin
          if (rq.size() > 0) cur = rq.pop_front();
          else check("responder_queue_empty", 1, 0);
          n = 0;
        end
        ready  = 1'($urandom_range(0, 1));
        perr   = 1'($urandom_range(0, 1));
        prdata = $urandom;
      end
    end
  end

  // Monitor: bus fields against the in-flight transfer, responses against the scoreboard.
  initial begin
    exp_t e;
    logic prev_psel = 1'b0;
    int   gap = 0;
    forever begin
      @(negedge pclk);
      if (prst) begin
        prev_psel = 1'b0;
        gap = 0;
      end else begin
        if (psel && !prev_psel) gaps.push_back(gap);
        if (psel) gap = 0;
        else gap++;
        prev_psel = psel;
        if (psel) begin
          if (penable) access_seen++;
          else setup_seen++;
          if (sb.size() == 0) begin
            check("bus_without_request", 1, 0);
          end else begin
            check(penable ? "access_paddr" : "setup_paddr", 64'(paddr), 64'(sb[0].addr));
            check(penable ? "access_pdata" : "setup_pdata", 64'(pdata), 64'(sb[0].wdata));
            check(penable ? "access_pwrite" : "setup_pwrite", 64'(pwrite), 64'(sb[0].write));
            check(penable ? "access_pstb" : "setup_pstb", 64'(pstb), 64'(sb[0].stb));
          end
        end
        if (rsp_valid) begin
          rsp_cycles.push_back(cyc);
          if (sb.size() == 0) begin
            check("unexpected_rsp_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.latency));
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_psel"}, 64'(psel), 0);
    check({tag, "_penable"}, 64'(penable), 0);
    check({tag, "_pwrite"}, 64'(pwrite), 0);
    check({tag, "_paddr"}, 64'(paddr), 0);
    check({tag, "_pdata"}, 64'(pdata), 0);
    check({tag, "_pstb"}, 64'(pstb), 0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 0);
  endtask

  initial begin
    int s0, a0, g;
    repeat (3) @(posedge pclk);
    #2;
    check_outputs_zero("reset");
    @(posedge pclk);
    #1;
    prst = 1'b0;
    @(negedge pclk);
    check("ready_after_reset", 64'(req_ready), 1);
    @(posedge pclk);
    #1;

    // write, one wait cycle
    s0 = setup_seen;
    a0 = access_seen;
    send(32'h1000_0000, 32'h41, 1'b1, 4'b0001, 1, 32'h0, 1'b0);
    drain();
    check("write_setup_cycles", 64'(setup_seen - s0), 1);
    check("write_access_cycles", 64'(access_seen - a0), 2);

    // read, three wait cycles; also ready coincides with expiry (TO=4)
    send(32'h20, 32'h0, 1'b0, 4'b1111, 3, 32'hDEADBEEF, 1'b0);
    drain();

    // error with ready
    send(32'h24, 32'h0, 1'b0, 4'b0000, 0, 32'h1234_5678, 1'b1);
    drain();

    // timeout, then ready at expiry with perr both ways
    send(32'h30, 32'h0, 1'b0, 4'b0000, 10, 32'hCAFE_F00D, 1'b0);
    drain();
    send(32'h34, 32'h0, 1'b0, 4'b0000, TO - 1, 32'h0BAD_0001, 1'b1);
    drain();
    send(32'h38, 32'h5, 1'b1, 4'b0011, TO - 1, 32'h0BAD_0002, 1'b0);
    drain();

    // back-to-back writes with zero-wait responder
    gaps.delete();
    rsp_cycles.delete();
    for (int i = 0; i < 3; i++)
      send(32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b1, 4'b1111, 0, 32'h0, 1'b0);
    drain();
    check("b2b_psel_rises", 64'(gaps.size()), 3);
    check("b2b_rsp_count", 64'(rsp_cycles.size()), 3);
    if (gaps.size() == 3) begin
      check("b2b_gap_1", 64'(gaps[1]), 1);
      check("b2b_gap_2", 64'(gaps[2]), 1);
    end
    if (rsp_cycles.size() == 3) begin
      check("b2b_spacing_1", 64'(rsp_cycles[1] - rsp_cycles[0]), 3);
      check("b2b_spacing_2", 64'(rsp_cycles[2] - rsp_cycles[1]), 3);
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge pclk);
        #1;
      end
    end
    drain();

    // reset in the middle of ACCESS
    send(32'hFFFF_0000, 32'h77, 1'b1, 4'b1010, 10, 32'h0, 1'b0);
    req_valid = 1'b0;
    g = 0;
    while (!(psel && penable) && g < 20) begin
      @(negedge pclk);
      g++;
    end
    check("reached_access", 64'(psel && penable), 1);
    #2;
    prst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    sb.delete();
    rq.delete();
    @(posedge pclk);
    @(posedge pclk);
    #1;
    prst = 1'b0;
    @(negedge pclk);
    check("ready_after_midreset", 64'(req_ready), 1);
    repeat (10) @(negedge pclk);
    check("no_rsp_after_reset", 64'(rsp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
